// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, legal oversampling
// ratios, default frame width and the 2-of-3 majority vote helper.
package uart_pkg;

  localparam int DATA_W_DEF = 8;

  // Oversampling ratios the receiver and transmitter are built for.
  localparam int PRESC_8  = 8;
  localparam int PRESC_16 = 16;
  localparam int PRESC_32 = 32;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  // True when at least two of the three samples are high.
  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/rx_sampler.sv
// Per-bit timing for the UART receiver: edge counter inside each bit and a
// three-sample majority vote around mid-bit.
module rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESC_W = 6
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               rx_i,
  // Start of frame seen in IDLE; that cycle already counts as edge 0.
  input  logic               load_i,
  // Frame in progress; counter and sampling run only while high.
  input  logic               en_i,
  input  logic [PRESC_W-1:0] presc_i,
  output logic               bit_val_o,
  output logic               bit_end_o
);

  logic [PRESC_W-1:0] edge_q, edge_d;
  logic [2:0]         samp_q, samp_d;
  logic [PRESC_W-1:0] half;
  logic [PRESC_W-1:0] last;

  // An illegal ratio only changes where the samples land; the counter
  // always wraps, so bit_end keeps coming and the FSM cannot stall.
  assign half      = presc_i >> 1;
  assign last      = presc_i - PRESC_W'(1);
  assign bit_end_o = en_i && (edge_q == last);
  assign bit_val_o = maj3(samp_q);

  // Next edge count and sample capture points.
  always_comb begin
    edge_d = edge_q;
    samp_d = samp_q;
    if (load_i) begin
      edge_d = PRESC_W'(1);
    end else if (en_i) begin
      edge_d = bit_end_o ? '0 : edge_q + PRESC_W'(1);
    end else begin
      edge_d = '0;
    end
    if (en_i) begin
      if (edge_q == half - PRESC_W'(1)) samp_d[0] = rx_i;
      if (edge_q == half)               samp_d[1] = rx_i;
      if (edge_q == half + PRESC_W'(1)) samp_d[2] = rx_i;
    end
  end

  // Counter and sample registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      edge_q <= '0;
      samp_q <= '0;
    end else begin
      edge_q <= edge_d;
      samp_q <= samp_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start detection, LSB-first deserialisation,
// optional parity check and stop check, with registered one-cycle pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic               PAR_EN,
  input  logic               PAR_TYP,
  output logic [DATA_W-1:0]  P_DATA,
  output logic               data_valid,
  output logic               par_err,
  output logic               stp_err,
  output rx_state_e          dbg_state_o
);

  localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

  rx_state_e          state_q;
  logic [BCW-1:0]     bit_cnt_q;
  logic [DATA_W-1:0]  shift_q;
  logic [DATA_W-1:0]  pdata_q;
  logic               perr_q;
  logic               dv_q, pe_q, se_q;
  logic [PRESC_W-1:0] presc_q;
  logic               par_en_q, par_typ_q;

  logic bit_val, bit_end;
  logic start_det;

  assign start_det = (state_q == RX_IDLE) && !RX_IN;

  rx_sampler #(.PRESC_W(PRESC_W)) u_sampler (
    .clk_i     (CLK),
    .rst_ni    (RST),
    .rx_i      (RX_IN),
    .load_i    (start_det),
    .en_i      (state_q != RX_IDLE),
    .presc_i   (presc_q),
    .bit_val_o (bit_val),
    .bit_end_o (bit_end)
  );

  // Frame state machine, deserializer, parity/stop checks and output pulses.
  // Frame settings are captured when a frame starts so later input changes
  // cannot disturb it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= RX_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      pdata_q   <= '0;
      perr_q    <= 1'b0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
      presc_q   <= PRESC_W'(PRESC_8);
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      pe_q <= 1'b0;
      se_q <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (!RX_IN) begin
            state_q   <= RX_START;
            presc_q   <= Prescale;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            perr_q    <= 1'b0;
          end
        end
        RX_START: begin
          if (bit_end) begin
            if (!bit_val) begin
              state_q   <= RX_DATA;
              bit_cnt_q <= '0;
            end else begin
              state_q <= RX_IDLE;
            end
          end
        end
        RX_DATA: begin
          if (bit_end) begin
            shift_q[bit_cnt_q] <= bit_val;
            if (bit_cnt_q == LAST_BIT) begin
              state_q <= par_en_q ? RX_PARITY : RX_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + BCW'(1);
            end
          end
        end
        RX_PARITY: begin
          if (bit_end) begin
            perr_q  <= (bit_val != ((^shift_q) ^ par_typ_q));
            state_q <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (bit_end) begin
            if (bit_val && !perr_q) begin
              pdata_q <= shift_q;
              dv_q    <= 1'b1;
            end
            se_q   <= !bit_val;
            pe_q   <= perr_q;
            perr_q <= 1'b0;
            // A low line here is taken as the next start bit.
            if (!RX_IN) begin
              state_q   <= RX_START;
              presc_q   <= Prescale;
              par_en_q  <= PAR_EN;
              par_typ_q <= PAR_TYP;
            end else begin
              state_q <= RX_IDLE;
            end
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign P_DATA      = pdata_q;
  assign data_valid  = dv_q;
  assign par_err     = pe_q;
  assign stp_err     = se_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver: the receive-side counterpart of the UART transmitter in the low-power multi-clock system. It sits in the UART clock domain and detects a start bit on the serial line. It recovers 8 data bits (LSB first), an optional parity bit and a stop bit by majority-voting three samples taken around mid-bit. It presents each good byte as a one-cycle `data_valid` pulse, and flags parity and framing errors. Frame format and parity convention match the transmitter: idle-high line, even parity when `PAR_TYP=0`.

## Interface
- `DATA_W`, 8, data bits per frame
- `PRESC_W`, 6, width of the `Prescale` input
- `CLK` input 1: receiver oversampling clock
- `RST` input 1: asynchronous, active-low reset
- `RX_IN` input 1: serial line, idle high; treated as already synchronized
- `Prescale` input PRESC_W: oversampling ratio; legal values are 8, 16 and 32
- `PAR_EN` input 1: 1 means the frame carries a parity bit
- `PAR_TYP` input 1: 0 = even parity, 1 = odd parity
- `P_DATA` output DATA_W: last received byte; held until the next good frame
- `data_valid` output 1: one-cycle pulse marking a good frame on `P_DATA`
- `par_err` output 1: one-cycle pulse, parity mismatch
- `stp_err` output 1: one-cycle pulse, stop bit sampled as 0

## Operation
- **States:** IDLE, START, DATA, PARITY, STOP.
- **Counters:** an edge counter runs 0..Prescale-1 inside each bit; a bit counter runs 0..DATA_W-1 in DATA.
- **IDLE:**
  - On `RX_IN`=0, go to START with edge_cnt=0.
  - Latch `Prescale`, `PAR_EN` and `PAR_TYP` for the whole frame; later changes to these inputs do not affect the frame in progress.
- **Sampling:** capture `RX_IN` at edge_cnt = P/2-1, P/2 and P/2+1. The bit value is the majority (2 of 3) of these samples.
- **START:** at edge_cnt=P-1:
  - sampled 0 → go to DATA;
  - sampled 1 → glitch; return to IDLE with no flags.
- **DATA:**
  - Shift the sampled bit into bit position bit_cnt (LSB first).
  - After bit DATA_W-1 completes, go to PARITY if `PAR_EN`=1, otherwise to STOP.
- **PARITY:**
  - Expected bit = XOR of the data bits, inverted when `PAR_TYP`=1.
  - A mismatch sets an internal error flag, which is reported at the end of the frame.
- **STOP, at edge_cnt=P-1:**
  - **Stop sampled 1 and no parity error:** load `P_DATA` and pulse `data_valid`.
  - **Stop sampled 0:** pulse `stp_err`. `P_DATA` is not updated and `data_valid` does not pulse.
  - **Parity error:** pulse `par_err`. `P_DATA` is not updated.
  - **Both errors:** pulse `par_err` and `stp_err` in the same cycle.
  - **Next state:** START if `RX_IN`=0 in that cycle (back-to-back frames, edge_cnt restarts at 0), otherwise IDLE.
- **Illegal `Prescale`:** behaviour is undefined. The state machine must still always return to IDLE and never lock up.

## Timing
- **Reset:** `P_DATA`=0, `data_valid`=0, `par_err`=0, `stp_err`=0; state=IDLE; all counters 0.
- **Mid-frame reset:** takes effect immediately. It aborts the frame with no pulse; reception resumes at the next falling edge after release.
- **Frame length:**
  - N = 1 + DATA_W + PAR_EN + 1 bits.
  - `data_valid` and the error pulses are registered outputs. They are high in cycle N·P, counted from the first low cycle of `RX_IN` in IDLE as cycle 0; this is exactly 1 cycle after the stop bit's edge_cnt=P-1.
- **Output pulses:** every pulse lasts exactly 1 cycle. `P_DATA` changes only in the same cycle that `data_valid` rises.
- **No handshake:** there is no backpressure; the consumer must take `P_DATA` on the pulse or before the next good frame.
- **Throughput:** back-to-back frames with zero idle cycles are received with no loss.

## Structure
- **Shared package `uart_pkg`:**
  - the receiver state enum (IDLE/START/DATA/PARITY/STOP);
  - the legal prescale constants 8/16/32;
  - the `DATA_W` default, shared with the transmitter.
- **Sub-module `rx_sampler`:**
  - owns the edge counter and the three-sample majority vote;
  - outputs `bit_val` and `bit_end` (edge_cnt=P-1);
  - the state machine, bit counter, deserializer and checks stay in the top level.

## Test plan
- **Good frame, no parity:** Prescale=8, PAR_EN=0, byte 0xA5, 10-bit frame → `data_valid` high exactly at cycle 80, `P_DATA`=0xA5, no error pulses.
- **Even parity:** Prescale=16, PAR_EN=1, PAR_TYP=0, byte 0xA5 with parity bit 0 → good frame, `P_DATA`=0xA5 at cycle 176. The same frame with parity bit 1 → `par_err` pulse, no `data_valid`, `P_DATA` unchanged.
- **Odd parity and stop error:** PAR_TYP=1, byte 0x01 with parity bit 0 → good frame. Byte 0x3C with stop bit 0 → `stp_err` only.
- **Start glitch:** `RX_IN` low for 3 cycles at Prescale=8 → return to IDLE, no pulses. A valid frame 0x5A sent afterwards → received correctly.
- **Noise and back-to-back:**
  - one corrupted sample at P/2-1 in every data bit → bytes still recovered by majority vote;
  - frames 0x11 then 0xEE with zero idle → two `data_valid` pulses 80 cycles apart (Prescale=8).
- **Reset mid-frame:** assert `RST` low during bit 4 of 0xC3 → all outputs 0, state IDLE. Frame 0x7E sent after release → received correctly.
